// File: rtl/sap2_bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus width, default requester count.
package sap2_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int BUS_WIDTH = 16;
    localparam int DEF_N_REQ = 4;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner select: first set request strictly above rr_ptr, wrapping to 0.
module rr_pick
    import sap2_bus_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]          req,
    input  logic [idx_w(N_REQ)-1:0]   rr_ptr,
    output logic                      valid,
    output logic [idx_w(N_REQ)-1:0]   winner
);

    localparam int IW = idx_w(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic               found;

    // Lower copy masked up to rr_ptr; the upper copy supplies the wrapped candidates.
    always_comb begin
        dbl    = {req, req};
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i <= 32'(rr_ptr)) dbl[i] = 1'b0;
        end
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (!found && dbl[i]) begin
                winner = IW'(i % N_REQ);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered grants and zero-default AND-OR bus mux.
// Optional forced revoke of contended owners under `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import sap2_bus_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = BUS_WIDTH,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data_in,
    output logic [N_REQ-1:0]         grant,
    output logic [idx_w(N_REQ)-1:0]  owner_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         bus,
    output logic                     revoked
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              pick_valid;
    logic [IW-1:0]     pick_winner;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          revoked_q, revoked_d;
    logic          contended;

    assign contended = |(req & ~grant_q);
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        revoked_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d              = OWNED;
                    grant_d              = '0;
                    grant_d[pick_winner] = 1'b1;
                    owner_d              = pick_winner;
                    ptr_d                = pick_winner;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d               = '0;
`endif
                end
            end
            OWNED: begin
                if (!req[owner_q]) begin
                    state_d = TURN;
                    grant_d = '0;
                    owner_d = '0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                // rr_ptr is left at the revoked owner so it is served last.
                else if (contended) begin
                    if (hold_q == HW'(MAX_HOLD - 1)) begin
                        state_d   = TURN;
                        grant_d   = '0;
                        owner_d   = '0;
                        revoked_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(N_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q    <= '0;
            revoked_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            revoked_q <= revoked_d;
`endif
        end
    end

    always_comb begin
        bus = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            bus |= data_in[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}};
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_q;
    assign busy     = |grant_q;

`ifdef BUS_ARB_TIMEOUT_EN
    assign revoked = revoked_q;
`else
    assign revoked = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed tables, corner sequences, random vs. model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MH = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic [1:0]     owner_id;
    logic           busy;
    logic [W-1:0]   bus;
    logic           revoked;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: owner (-1 when none), dead cycles left before arbitration,
    // last winner, contended-cycle count, revoke pulse.
    int m_owner, m_gap, m_last, m_cnt;
    bit m_rev;

    typedef struct {
        bit           rst_before;
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t tbl[$];

    bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .owner_id (owner_id),
        .busy     (busy),
        .bus      (bus),
        .revoked  (revoked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_gap   = 0;
        m_last  = N - 1;
        m_cnt   = 0;
        m_rev   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] r);
        m_rev = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = 1;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if ((r & ~(N'(1) << m_owner)) != '0) begin
                m_cnt++;
                if (m_cnt == MH) begin
                    m_rev   = 1'b1;
                    m_owner = -1;
                    m_gap   = 1;
                end
            end
`endif
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (r[j]) begin
                    m_owner = j;
                    m_last  = j;
                    m_cnt   = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        int           eo;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        eb = (m_owner >= 0) ? data_in[m_owner*W +: W] : '0;
        eo = (m_owner >= 0) ? m_owner : 0;
        chk({tag, "_grant"},   32'(grant),    32'(eg));
        chk({tag, "_owner"},   32'(owner_id), 32'(eo));
        chk({tag, "_busy"},    32'(busy),     32'(m_owner >= 0));
        chk({tag, "_bus"},     32'(bus),      32'(eb));
        chk({tag, "_revoked"}, 32'(revoked),  32'(m_rev));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #2;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // Test 1: single request, release, two dead cycles.
        tbl.push_back('{1'b1, 4'b0010, 4'b0010});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000});
        // Test 2: all requesting, 3-cycle tenures, rotation 0,1,2,3,0.
        tbl.push_back('{1'b1, 4'b1111, 4'b0001});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001});
        tbl.push_back('{1'b0, 4'b1110, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010});
        tbl.push_back('{1'b0, 4'b1101, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100});
        tbl.push_back('{1'b0, 4'b1011, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000});
        tbl.push_back('{1'b0, 4'b0111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001});

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            req     = tbl[i].req;
            data_in = {$urandom, $urandom};
            step("tbl");
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
        end

        // Test 3: no preemption of owner 2, then wrap to index 0.
        do_reset();
        req = 4'b0100;
        step("t3");
        req = 4'b0101;
        repeat (3) step("t3");
        chk("t3_nopreempt", 32'(grant), 32'(4'b0100));
        req = 4'b0001;
        repeat (3) step("t3");
        chk("t3_wrap", 32'(grant), 32'(4'b0001));

        // Test 4: asynchronous reset mid-tenure.
        req = 4'b0011;
        repeat (2) step("t4");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t4_async_grant", 32'(grant), 32'(0));
        chk("t4_async_bus",   32'(bus),   32'(0));
        chk("t4_async_busy",  32'(busy),  32'(0));
        model_reset();
        req = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        step("t4");
        chk("t4_after", 32'(grant), 32'(4'b0001));

`ifdef BUS_ARB_TIMEOUT_EN
        // Test 5: contended owner revoked after MAX_HOLD cycles, uncontended never.
        do_reset();
        req = 4'b0010;
        step("t5");
        req = 4'b1010;
        repeat (MH - 1) step("t5");
        chk("t5_not_yet", 32'(revoked), 32'(0));
        step("t5");
        chk("t5_revoked", 32'(revoked), 32'(1));
        chk("t5_cleared", 32'(grant),   32'(0));
        repeat (2) step("t5");
        chk("t5_next", 32'(grant), 32'(4'b1000));
        do_reset();
        req = 4'b0010;
        repeat (21) step("t5alone");
        chk("t5_alone", 32'(grant), 32'(4'b0010));
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = ~req[i];
                end
            end
            data_in = {$urandom, $urandom};
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
